// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg
//   Shared definitions for the fetch-stage PC sequencer:
//     - fetch_state_e  : FSM state encoding (FS_REQ, FS_WAIT, FS_HOLD)
//     - FETCH_PC_RESET : default fetch PC after reset
//     - FETCH_NOP_WORD : default bubble instruction word
//     - ADEL_LO/ADEL_HI: legal instruction address window (inclusive)
//     - fetch_addr_ok(): alignment + window check, used when FETCH_ADEL_EN is defined
package fetch_pc_unit_pkg;

   typedef enum logic [1:0] {
      FS_REQ  = 2'd0,
      FS_WAIT = 2'd1,
      FS_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] FETCH_PC_RESET = 32'h0000_3000;
   localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;

   localparam logic [31:0] ADEL_LO = 32'h0000_3000;
   localparam logic [31:0] ADEL_HI = 32'h0000_6FFF;

   // True when pc is word aligned and inside the instruction window.
   function automatic logic fetch_addr_ok(input logic [31:0] pc);
      return (pc[1:0] == 2'b00) && (pc >= ADEL_LO) && (pc <= ADEL_HI);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
//   Instruction-memory fetch channel between the fetch sequencer and the memory.
//     imem_req   : fetch request, one-cycle pulse, accepted in the same cycle
//     imem_addr  : word fetch address
//     imem_valid : response valid; must be taken the cycle it is raised
//     imem_rdata : response instruction word
//   modport master : fetch side (drives req/addr)
//   modport slave  : memory side (drives valid/rdata)
interface fetch_pc_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_valid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Fetch-stage sequencer. Owns the F-stage PC and the F/D pipeline register,
//   issues word fetches to a variable-latency instruction memory and buffers a
//   returned word while the hazard unit stalls D.
//
//   Ports
//     clk        : clock, all state updates on the rising edge
//     reset      : synchronous, active-low
//     npc_in     : next PC from the next-PC logic (computed from f_pc / d_pc)
//     stall      : hazard unit asks D to hold
//     f_pc       : current fetch PC
//     imem       : fetch channel (fetch_pc_unit_if.master)
//     d_pc       : PC of the instruction in D
//     d_instr    : instruction in D (NOP_WORD when D holds a bubble)
//     d_valid    : D holds a real instruction
//     f_wait     : fetch not yet delivered; hazard unit must hold D, bubble E
//     d_exc_adel : address-error flag travelling with D (FETCH_ADEL_EN only)
//
//   Configuration macro
//     FETCH_ADEL_EN : when defined, a misaligned or out-of-window f_pc is caught
//                     in FS_REQ; no fetch is issued and a NOP_WORD is delivered
//                     with d_exc_adel set.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = FETCH_PC_RESET,
   parameter logic [31:0] NOP_WORD = FETCH_NOP_WORD
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            npc_in,
   input  logic                   stall,
   output logic [31:0]            f_pc,
   fetch_pc_unit_if.master        imem,
   output logic [31:0]            d_pc,
   output logic [31:0]            d_instr,
   output logic                   d_valid,
`ifdef FETCH_ADEL_EN
   output logic                   d_exc_adel,
`endif
   output logic                   f_wait
);

   fetch_state_e state_q;
   logic [31:0]  f_pc_q;
   logic [31:0]  d_pc_q;
   logic [31:0]  d_instr_q;
   logic         d_valid_q;
   logic [31:0]  hold_buf_q;

   logic         addr_ok;
   logic         deliver;
   logic [31:0]  deliver_word;

`ifdef FETCH_ADEL_EN
   logic         hold_adel_q;
   logic         d_exc_adel_q;

   assign addr_ok = fetch_addr_ok(f_pc_q);
`else
   assign addr_ok = 1'b1;
`endif

   // A word reaches D either straight from memory (WAIT) or from the hold
   // buffer (HOLD); in both cases only when D is not stalled.
   always_comb begin
      deliver      = 1'b0;
      deliver_word = hold_buf_q;
      unique case (state_q)
         FS_WAIT: begin
            if (imem.imem_valid && !stall) begin
               deliver      = 1'b1;
               deliver_word = imem.imem_rdata;
            end
         end
         FS_HOLD: begin
            if (!stall) begin
               deliver = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= FS_REQ;
         f_pc_q     <= PC_RESET;
         d_pc_q     <= '0;
         d_instr_q  <= NOP_WORD;
         d_valid_q  <= 1'b0;
         hold_buf_q <= '0;
`ifdef FETCH_ADEL_EN
         hold_adel_q  <= 1'b0;
         d_exc_adel_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            FS_REQ: begin
               // A late imem_valid from an abandoned fetch lands here and is ignored.
               if (addr_ok) begin
                  state_q <= FS_WAIT;
               end else begin
                  state_q    <= FS_HOLD;
                  hold_buf_q <= NOP_WORD;
               end
`ifdef FETCH_ADEL_EN
               hold_adel_q <= !addr_ok;
`endif
            end
            FS_WAIT: begin
               if (imem.imem_valid) begin
                  if (stall) begin
                     // No backpressure to memory: park the word until D frees up.
                     hold_buf_q <= imem.imem_rdata;
                     state_q    <= FS_HOLD;
                  end else begin
                     state_q <= FS_REQ;
                  end
               end
            end
            FS_HOLD: begin
               if (!stall) begin
                  state_q <= FS_REQ;
               end
            end
            default: begin
               state_q <= FS_REQ;
            end
         endcase

         // f_pc moves only with a delivery, so npc_in is sampled while D still
         // holds the previous instruction (branch in D, delay slot at f_pc).
         if (deliver) begin
            d_pc_q    <= f_pc_q;
            d_instr_q <= deliver_word;
            d_valid_q <= 1'b1;
            f_pc_q    <= npc_in;
`ifdef FETCH_ADEL_EN
            d_exc_adel_q <= hold_adel_q && (state_q == FS_HOLD);
`endif
         end
      end
   end

   assign imem.imem_req  = reset && (state_q == FS_REQ) && addr_ok;
   assign imem.imem_addr = f_pc_q;

   assign f_pc    = f_pc_q;
   assign d_pc    = d_pc_q;
   assign d_instr = d_instr_q;
   assign d_valid = d_valid_q;
   assign f_wait  = (state_q != FS_HOLD);
`ifdef FETCH_ADEL_EN
   assign d_exc_adel = d_exc_adel_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

   logic        clk;
   logic        reset;
   logic [31:0] npc_in;
   logic        stall;
   logic [31:0] f_pc;
   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic        d_valid;
   logic        f_wait;
`ifdef FETCH_ADEL_EN
   logic        d_exc_adel;
`endif

   fetch_pc_unit_if imem_bus ();

   fetch_pc_unit dut (
      .clk        (clk),
      .reset      (reset),
      .npc_in     (npc_in),
      .stall      (stall),
      .f_pc       (f_pc),
      .imem       (imem_bus.master),
      .d_pc       (d_pc),
      .d_instr    (d_instr),
      .d_valid    (d_valid),
`ifdef FETCH_ADEL_EN
      .d_exc_adel (d_exc_adel),
`endif
      .f_wait     (f_wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic        rst;
      logic [31:0] npc;
      logic        st;
      logic        v;
      logic [31:0] rd;
      logic        chk_pre;
      logic        req;
      logic [31:0] addr;
      logic        fw;
      logic [31:0] fpc;
      logic [31:0] dpc;
      logic [31:0] di;
      logic        dv;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(input logic rst, input logic [31:0] npc, input logic st,
                               input logic v, input logic [31:0] rd, input logic chk_pre,
                               input logic req, input logic [31:0] addr, input logic fw,
                               input logic [31:0] fpc, input logic [31:0] dpc,
                               input logic [31:0] di, input logic dv);
      vec_t r;
      r.rst = rst; r.npc = npc; r.st = st; r.v = v; r.rd = rd;
      r.chk_pre = chk_pre; r.req = req; r.addr = addr; r.fw = fw;
      r.fpc = fpc; r.dpc = dpc; r.di = di; r.dv = dv;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [31:0] npc, input logic st,
                        input logic v, input logic [31:0] rd);
      reset               = rst;
      npc_in              = npc;
      stall               = st;
      imem_bus.imem_valid = v;
      imem_bus.imem_rdata = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef FETCH_ADEL_EN
   // From FS_REQ at a legal f_pc: fetch, deliver, so f_pc becomes bad_pc; then
   // expect the bad address to be trapped and a flagged NOP to reach D.
   task automatic adel_run(input logic [31:0] bad_pc, input logic [31:0] legal_next);
      drive(1'b1, bad_pc, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b1, bad_pc, 1'b0, 1'b1, 32'h1111_0007);
      tick();
      check("adel_fpc_bad", f_pc, bad_pc);
      drive(1'b1, legal_next, 1'b0, 1'b0, 32'h0);
      #2;
      check("adel_no_req", {31'b0, imem_bus.imem_req}, 32'd0);
      tick();
      check("adel_hold_fwait", {31'b0, f_wait}, 32'd0);
      tick();
      check("adel_d_instr", d_instr, 32'h0);
      check("adel_flag", {31'b0, d_exc_adel}, 32'd1);
      check("adel_fpc_next", f_pc, legal_next);
      drive(1'b1, legal_next + 32'd4, 1'b0, 1'b0, 32'h0);
      #2;
      check("adel_next_req", {31'b0, imem_bus.imem_req}, 32'd1);
      tick();
      drive(1'b1, legal_next + 32'd4, 1'b0, 1'b1, 32'h1111_0008);
      tick();
      check("adel_flag_clr", {31'b0, d_exc_adel}, 32'd0);
      check("adel_legal_instr", d_instr, 32'h1111_0008);
   endtask
`endif

   initial begin
      int req_seen;
      int found;

      // rst npc st v rd | chk_pre req addr fw | fpc dpc di dv
      vecs[0]  = mk(0, 32'h0,    0, 0, 32'h0,         0, 0, 32'h0,    1,
                    32'h3000, 32'h0,    32'h0,         0);
      vecs[1]  = mk(0, 32'h0,    0, 1, 32'hDEAD_BEEF, 1, 0, 32'h3000, 1,
                    32'h3000, 32'h0,    32'h0,         0);
      vecs[2]  = mk(1, 32'h3004, 0, 0, 32'h0,         1, 1, 32'h3000, 1,
                    32'h3000, 32'h0,    32'h0,         0);
      vecs[3]  = mk(1, 32'h3004, 0, 1, 32'h1111_0001, 1, 0, 32'h3000, 1,
                    32'h3004, 32'h3000, 32'h1111_0001, 1);
      vecs[4]  = mk(1, 32'h3008, 0, 0, 32'h0,         1, 1, 32'h3004, 1,
                    32'h3004, 32'h3000, 32'h1111_0001, 1);
      vecs[5]  = mk(1, 32'h3008, 0, 0, 32'h0,         1, 0, 32'h3004, 1,
                    32'h3004, 32'h3000, 32'h1111_0001, 1);
      vecs[6]  = mk(1, 32'h3008, 0, 1, 32'h1111_0002, 1, 0, 32'h3004, 1,
                    32'h3008, 32'h3004, 32'h1111_0002, 1);
      vecs[7]  = mk(1, 32'h300C, 0, 0, 32'h0,         1, 1, 32'h3008, 1,
                    32'h3008, 32'h3004, 32'h1111_0002, 1);
      vecs[8]  = mk(1, 32'h300C, 1, 1, 32'h1234_5678, 1, 0, 32'h3008, 1,
                    32'h3008, 32'h3004, 32'h1111_0002, 1);
      vecs[9]  = mk(1, 32'h300C, 1, 0, 32'h0,         1, 0, 32'h3008, 0,
                    32'h3008, 32'h3004, 32'h1111_0002, 1);
      vecs[10] = mk(1, 32'h300C, 1, 0, 32'h0,         1, 0, 32'h3008, 0,
                    32'h3008, 32'h3004, 32'h1111_0002, 1);
      vecs[11] = mk(1, 32'h300C, 1, 0, 32'h0,         1, 0, 32'h3008, 0,
                    32'h3008, 32'h3004, 32'h1111_0002, 1);
      vecs[12] = mk(1, 32'h300C, 0, 0, 32'h0,         1, 0, 32'h3008, 0,
                    32'h300C, 32'h3008, 32'h1234_5678, 1);
      vecs[13] = mk(1, 32'h3010, 0, 0, 32'h0,         1, 1, 32'h300C, 1,
                    32'h300C, 32'h3008, 32'h1234_5678, 1);
      vecs[14] = mk(1, 32'h3010, 0, 1, 32'h1111_0003, 1, 0, 32'h300C, 1,
                    32'h3010, 32'h300C, 32'h1111_0003, 1);
      vecs[15] = mk(1, 32'h3014, 0, 0, 32'h0,         1, 1, 32'h3010, 1,
                    32'h3010, 32'h300C, 32'h1111_0003, 1);
      vecs[16] = mk(1, 32'h3014, 0, 1, 32'h1000_0004, 1, 0, 32'h3010, 1,
                    32'h3014, 32'h3010, 32'h1000_0004, 1);
      // Branch in D at 3010, delay slot at 3014; next-PC logic offers the target.
      vecs[17] = mk(1, 32'h3040, 0, 0, 32'h0,         1, 1, 32'h3014, 1,
                    32'h3014, 32'h3010, 32'h1000_0004, 1);
      vecs[18] = mk(1, 32'h3040, 0, 1, 32'h1111_0005, 1, 0, 32'h3014, 1,
                    32'h3040, 32'h3014, 32'h1111_0005, 1);
      vecs[19] = mk(1, 32'h3044, 0, 0, 32'h0,         1, 1, 32'h3040, 1,
                    32'h3040, 32'h3014, 32'h1111_0005, 1);
      // Reset while in WAIT, then a stale response lands in REQ.
      vecs[20] = mk(0, 32'h3044, 0, 0, 32'h0,         1, 0, 32'h3040, 1,
                    32'h3000, 32'h0,    32'h0,         0);
      vecs[21] = mk(1, 32'h3004, 0, 1, 32'hBAD0_BAD0, 1, 1, 32'h3000, 1,
                    32'h3000, 32'h0,    32'h0,         0);
      vecs[22] = mk(1, 32'h3004, 0, 1, 32'h1111_0006, 1, 0, 32'h3000, 1,
                    32'h3004, 32'h3000, 32'h1111_0006, 1);
      vecs[23] = mk(1, 32'h3008, 0, 0, 32'h0,         1, 1, 32'h3004, 1,
                    32'h3004, 32'h3000, 32'h1111_0006, 1);

      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].rst, vecs[i].npc, vecs[i].st, vecs[i].v, vecs[i].rd);
         #2;
         if (vecs[i].chk_pre) begin
            check($sformatf("v%0d_req", i), {31'b0, imem_bus.imem_req}, {31'b0, vecs[i].req});
            check($sformatf("v%0d_addr", i), imem_bus.imem_addr, vecs[i].addr);
            check($sformatf("v%0d_fwait", i), {31'b0, f_wait}, {31'b0, vecs[i].fw});
         end
         tick();
         check($sformatf("v%0d_fpc", i), f_pc, vecs[i].fpc);
         check($sformatf("v%0d_dpc", i), d_pc, vecs[i].dpc);
         check($sformatf("v%0d_dinstr", i), d_instr, vecs[i].di);
         check($sformatf("v%0d_dvalid", i), {31'b0, d_valid}, {31'b0, vecs[i].dv});
`ifdef FETCH_ADEL_EN
         check($sformatf("v%0d_adel", i), {31'b0, d_exc_adel}, 32'd0);
`endif
      end

      // Stall held four cycles across the response: no refetch while holding.
      req_seen = 0;
      drive(1'b1, 32'h3008, 1'b1, 1'b1, 32'h1234_5678);
      #2;
      if (imem_bus.imem_req) req_seen++;
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h3008, 1'b1, 1'b0, 32'h0);
         #2;
         if (imem_bus.imem_req) req_seen++;
         tick();
      end
      check("stall_req_count", req_seen, 32'd0);
      check("stall_d_hold", d_instr, 32'h1111_0006);
      check("stall_fpc_hold", f_pc, 32'h3004);
      drive(1'b1, 32'h3008, 1'b0, 1'b0, 32'h0);
      tick();
      check("stall_release_instr", d_instr, 32'h1234_5678);
      check("stall_release_fpc", f_pc, 32'h3008);
      check("stall_release_dpc", d_pc, 32'h3004);

      // Next request must follow immediately, at the new PC.
      found = 0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h300C, 1'b0, 1'b0, 32'h0);
         #2;
         if (imem_bus.imem_req) begin
            found = k + 1;
            break;
         end
         tick();
      end
      check("next_req_latency", found, 32'd1);
      check("next_req_addr", imem_bus.imem_addr, 32'h3008);
      tick();
      // Now in WAIT; deliver to return to REQ at 300C.
      drive(1'b1, 32'h300C, 1'b0, 1'b1, 32'h1111_0009);
      tick();
      check("post_stall_fpc", f_pc, 32'h300C);

`ifdef FETCH_ADEL_EN
      adel_run(32'h0000_3002, 32'h0000_3010);
      adel_run(32'h0000_7000, 32'h0000_3020);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage sequencer: owns the F-stage PC register and the F/D pipeline register, and sits on the receive side of the next-PC interface.
- Each time an instruction is handed to D, it captures the next-PC value (`npc_in`) as the new `f_pc`.
- It issues word fetches to a variable-latency instruction memory and buffers the returned instruction across hazard stalls.
- It reports `f_wait` so the hazard unit can hold D while a fetch is outstanding.

Parameters:
- `PC_RESET`, 32'h0000_3000, value of `f_pc` after reset.
- `NOP_WORD`, 32'h0000_0000, value of `d_instr` when D holds a bubble.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low (0 = reset).
- `npc_in` input 32: next PC from the next-PC logic, which computes it from `f_pc` and `d_pc`.
- `stall` input 1: hazard unit requests D to hold.
- `f_pc` output 32: current fetch PC.
- `imem_req` output 1: fetch request, one-cycle pulse.
- `imem_addr` output 32: fetch address, equal to `f_pc`.
- `imem_valid` input 1: instruction memory response valid.
- `imem_rdata` input 32: response instruction word.
- `d_pc` output 32: PC of the instruction in D.
- `d_instr` output 32: instruction in D.
- `d_valid` output 1: D holds a real instruction.
- `f_wait` output 1: fetch not yet delivered; the hazard unit must hold D and bubble E.

Behaviour:
- Reset (`reset`=0 at an edge):
  - state=REQ, `f_pc`=`PC_RESET`, `d_pc`=0, `d_instr`=`NOP_WORD`, `d_valid`=0.
  - Hold buffer is cleared; `imem_req`=0 during the reset cycle.
  - Reset mid-fetch: any late `imem_valid` for the abandoned request arrives while the FSM is in REQ, where `imem_valid` is ignored.
- FSM states:
  - REQ: `imem_req`=1, `imem_addr`=`f_pc`, `f_wait`=1. Next state is WAIT unconditionally. Memory accepts the request in the same cycle.
  - WAIT: `f_wait`=1 until `imem_valid`.
    - `imem_valid` & !`stall` (delivery): `d_pc`<=`f_pc`, `d_instr`<=`imem_rdata`, `d_valid`<=1, `f_pc`<=`npc_in`; go to REQ.
    - `imem_valid` & `stall`: hold_buf<=`imem_rdata`; go to HOLD. D is unchanged.
    - `imem_valid` is required in the cycle it is raised; there is no backpressure to memory.
  - HOLD: `f_wait`=0.
    - !`stall`: deliver hold_buf exactly as above and go to REQ.
    - `stall`: remain in HOLD.
- D register update rule: D changes only on delivery. `stall` or `f_wait` never inserts a bubble into D.
- PC update rule:
  - `f_pc` changes only on delivery, so `npc_in` is sampled while D still holds the previous instruction.
  - This preserves delay-slot semantics: a branch in D and its delay slot at `f_pc` are consistent when `npc_in` is sampled.
- Latency: minimum two cycles per instruction (REQ, then WAIT with same-cycle `imem_valid`). Each extra memory cycle adds one.
- Width/arithmetic:
  - `f_pc` is stored verbatim; no +4 is done inside this block.
  - Wrap-around at 32'hFFFF_FFFC is the next-PC logic's concern.
- Simultaneous `stall` and `imem_valid`: the buffer path wins; no data is lost and no refetch occurs.

Optional Feature:
- Macro: `FETCH_ADEL_EN`.
- Defined:
  - A misaligned `f_pc` (bits [1:0]≠0) or an `f_pc` outside [32'h0000_3000, 32'h0000_6FFF] is checked in REQ.
  - On failure: no `imem_req` is issued, and the FSM goes directly to HOLD with hold_buf=`NOP_WORD`.
  - Extra output `d_exc_adel` (1 bit) is loaded with 1 on that delivery and 0 on every other delivery; reset value 0.
- Undefined:
  - No address check is performed and the `d_exc_adel` port does not exist.

Decomposition:
- Shared package/macro file holds:
  - FSM state encodings (`FS_REQ`=2'd0, `FS_WAIT`=2'd1, `FS_HOLD`=2'd2).
  - `PC_RESET` value.
  - AdEL address bounds.
- Single module; no sub-module. The F/D register is a few flops and is not worth splitting out.

Test Plan:
- Reset release, memory answers the cycle after each request:
  - `imem_addr`=32'h3000 with `imem_req`=1 in cycle 1.
  - `d_pc`=32'h3000 and `d_valid`=1 after cycle 2.
  - The next request carries `npc_in`=32'h3004.
- Three-cycle memory latency: `f_wait`=1 for three cycles, then D loads. `f_pc` is unchanged until delivery.
- `stall`=1 held for 4 cycles across `imem_valid` with `imem_rdata`=32'h1234_5678:
  - FSM enters HOLD and D is unchanged.
  - On `stall`=0, `d_instr`=32'h1234_5678 and `f_pc`=`npc_in`; no second request is issued.
- Branch delivery: with `d_pc`=32'h3010 (branch) and `f_pc`=32'h3014, drive `npc_in`=32'h3040.
  - After the delay slot is delivered, `d_pc`=32'h3014 and the next `imem_addr`=32'h3040.
- `reset`=0 asserted while in WAIT:
  - Next cycle: `f_pc`=32'h3000, `d_valid`=0.
  - A stale `imem_valid` arriving during reset or REQ is ignored.
- `FETCH_ADEL_EN`: `npc_in`=32'h3002, or `npc_in`=32'h7000 in a separate run.
  - No `imem_req` is issued.
  - `d_instr`=`NOP_WORD` and `d_exc_adel`=1; the next legal delivery clears `d_exc_adel`.
